// File: rtl/booth_mult_arbiter.sv
// rtl/booth_mult_arbiter.sv - two-requester round-robin front end for a shared Booth multiplier
//
// Purpose: arbitrates two requesters onto one multiplier datapath, launches
// it with a one-cycle start pulse, waits for done under a watchdog and returns
// the product (or a timeout error) to the requester that was granted.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   req{0,1}_valid/ready/a/b     operand request channels (ready is combinational)
//   rsp{0,1}_valid/ready         response channels
//   rsp{0,1}_product/err         signed 2N-bit product, timeout flag
//   dp_start                     one-cycle launch pulse to the datapath
//   dp_multiplicand/multiplier   operands to the datapath, held through WAIT
//   dp_done, dp_product          datapath completion pulse and its product
//   busy                         high whenever the arbiter is not idle
module booth_mult_arbiter #(
    parameter int N       = 16,
    parameter int TIMEOUT = 64,
    parameter int CW      = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [2*N-1:0] rsp0_product,
    output logic           rsp0_err,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [2*N-1:0] rsp1_product,
    output logic           rsp1_err,
    output logic           dp_start,
    output logic [N-1:0]   dp_multiplicand,
    output logic [N-1:0]   dp_multiplier,
    input  logic           dp_done,
    input  logic [2*N-1:0] dp_product,
    output logic           busy
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

    state_t         state, state_nx;
    logic           rr_ptr;     // requester served last
    logic           rr_vld;     // rr_ptr holds a real history entry
    logic           owner;
    logic [N-1:0]   op_a, op_b;
    logic [2*N-1:0] prod;
    logic           err;
    logic           rsp_vld;
    logic [CW-1:0]  cnt;

    logic grant_any, grant_sel, timeout_hit, rsp_hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        grant_any   = 1'b0;
        grant_sel   = 1'b0;
        timeout_hit = (cnt == CW'(TIMEOUT - 1));
        rsp_hs      = rsp_vld && (owner ? rsp1_ready : rsp0_ready);
        case (state)
            S_IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant_any = 1'b1;
                    // Until someone has been served, requester 0 wins a tie;
                    // afterwards the one not served last wins.
                    grant_sel = rr_vld ? ~rr_ptr : 1'b0;
                end else if (req0_valid || req1_valid) begin
                    grant_any = 1'b1;
                    grant_sel = req1_valid;
                end
                if (grant_any) state_nx = S_LAUNCH;
            end
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT:   if (dp_done || timeout_hit) state_nx = S_RESP;
            S_RESP:   if (rsp_hs) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= 1'b0;
            rr_vld  <= 1'b0;
            owner   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            prod    <= '0;
            err     <= 1'b0;
            rsp_vld <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        op_a  <= grant_sel ? req1_a : req0_a;
                        op_b  <= grant_sel ? req1_b : req0_b;
                        owner <= grant_sel;
                    end
                end
                S_LAUNCH: cnt <= '0;
                S_WAIT: begin
                    // done takes precedence over a coincident timeout
                    if (dp_done) begin
                        prod    <= dp_product;
                        err     <= 1'b0;
                        rsp_vld <= 1'b1;
                    end else if (timeout_hit) begin
                        prod    <= '0;
                        err     <= 1'b1;
                        rsp_vld <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_hs) begin
                        rsp_vld <= 1'b0;
                        err     <= 1'b0;
                        rr_ptr  <= owner;
                        rr_vld  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ready is gated by rst so every output is low while reset is held.
    assign req0_ready = rst && grant_any && !grant_sel;
    assign req1_ready = rst && grant_any && grant_sel;

    // A single response register is steered to the owner; the other side reads 0.
    assign rsp0_valid   = rsp_vld && !owner;
    assign rsp1_valid   = rsp_vld && owner;
    assign rsp0_err     = rsp0_valid && err;
    assign rsp1_err     = rsp1_valid && err;
    assign rsp0_product = rsp0_valid ? prod : '0;
    assign rsp1_product = rsp1_valid ? prod : '0;

    assign dp_start        = (state == S_LAUNCH);
    assign dp_multiplicand = op_a;
    assign dp_multiplier   = op_b;
    assign busy            = (state != S_IDLE);

endmodule
